md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- Owns the HI/LO registers and sequences the MULT/MULTU/DIV/DIVU latency.
- Applies MTHI/MTLO writes.
- Raises a D-stage stall request while any HI/LO-related instruction would collide with an operation in flight.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_arith.sv | 63 ++++++
 rtl/md_sched.sv | 98 +++++++++
 tb/tb_md_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared md_op encoding and scheduler state type
package md_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 64-bit mult/div result with MIPS sign and divide-by-zero rules
import md_pkg::*;

module md_arith (
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [31:0]        i_a,
    input  logic [31:0]        i_b,
    input  logic [31:0]        i_hi,
    input  logic [31:0]        i_lo,
    output logic [31:0]        o_hi,
    output logic [31:0]        o_lo
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_s;
    logic [31:0] w_div_u;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'b0, i_a} * {32'b0, i_b};

    // Signed divide via magnitudes: -2^31 / -1 wraps to 0x80000000 with no trap.
    assign w_mag_a = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_mag_b = i_b[31] ? (~i_b + 32'd1) : i_b;
    assign w_div_s = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_div_u = (i_b == 32'd0) ? 32'd1 : i_b;

    always_comb begin
        w_uq = w_mag_a / w_div_s;
        w_ur = w_mag_a % w_div_s;
        w_sq = (i_a[31] ^ i_b[31]) ? (~w_uq + 32'd1) : w_uq;
        w_sr = i_a[31] ? (~w_ur + 32'd1) : w_ur;
    end

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV: begin
                if (i_b != 32'd0) begin
                    o_hi = w_sr;
                    o_lo = w_sq;
                end
            end
            MD_DIVU: begin
                if (i_b != 32'd0) begin
                    o_hi = i_a % w_div_u;
                    o_lo = i_a / w_div_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - E-stage mult/div scheduler owning HI/LO and the D-stage stall request
// Optional MD_DIV0_FAST_EN: a divide by zero retires immediately without entering RUN.
import md_pkg::*;

module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic               md_use_d,
    output logic               busy,
    output logic               stall,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_buf;
    logic [31:0]        r_lo_buf;
    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;
    logic               w_launch;

    md_arith u_arith (
        .i_op (md_op),
        .i_a  (a),
        .i_b  (b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_hi_res),
        .o_lo (w_lo_res)
    );

`ifdef MD_DIV0_FAST_EN
    logic w_div0;
    assign w_div0   = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (b == 32'd0);
    assign w_launch = start & is_muldiv(md_op) & ~w_div0;
`else
    assign w_launch = start & is_muldiv(md_op);
`endif

    assign stall = md_use_d & (r_busy | w_launch);
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_buf <= 32'd0;
            r_lo_buf <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_hi_buf <= w_hi_res;
                        r_lo_buf <= w_lo_res;
                        r_cnt    <= is_mult(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else if (start && (md_op == MD_MTHI)) begin
                        r_hi <= a;
                    end else if (start && (md_op == MD_MTLO)) begin
                        r_lo <= a;
                    end
                end
                RUN: begin
                    // Results land as busy drops, so the retiring cycle already shows them.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_hi_buf;
                        r_lo    <= r_lo_buf;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched
`timescale 1ns/1ps
import md_pkg::*;

module tb_md_sched;

    logic               clk;
    logic               reset;
    logic               start;
    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic               md_use_d;
    logic               busy;
    logic               stall;
    logic [31:0]        hi;
    logic [31:0]        lo;

    int n_chk  = 0;
    int n_pass = 0;
    int n_busy;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(busy && start)) else $error("start issued while busy");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [MD_OP_W-1:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = '0; b = '0; md_use_d = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
        count_busy(n_busy);
        chk("mult_busy", n_busy, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        issue(MD_MULTU, 32'hFFFFFFFE, 32'd3);
        count_busy(n_busy);
        chk("multu_busy", n_busy, 32'd5);
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        count_busy(n_busy);
        chk("div_busy", n_busy, 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        issue(MD_DIVU, 32'd7, 32'd2);
        count_busy(n_busy);
        chk("divu_busy", n_busy, 32'd10);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n_busy);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'd0);

        issue(MD_DIV, 32'd100, 32'hFFFFFFF9);
        count_busy(n_busy);
        chk("divneg_lo", lo, 32'hFFFFFFF2);
        chk("divneg_hi", hi, 32'd2);

        issue(MD_MTLO, 32'h000000AA, 32'd0);
        issue(MD_MTHI, 32'h12345678, 32'd0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo", lo, 32'h000000AA);

        issue(MD_NONE, 32'hDEADBEEF, 32'd5);
        chk("none_busy", {31'b0, busy}, 32'd0);
        chk("none_hi", hi, 32'h12345678);
        chk("none_lo", lo, 32'h000000AA);

        md_use_d = 1'b1;
        start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd4;
        #1;
        chk("stall_issue", {31'b0, stall}, 32'd1);
        tick();
        start = 1'b0; md_op = MD_NONE;
        n_busy = 0;
        while (busy && n_busy < 50) begin
            chk("stall_busy", {31'b0, stall}, 32'd1);
            n_busy++;
            tick();
        end
        chk("stall_cnt", n_busy, 32'd5);
        chk("stall_after", {31'b0, stall}, 32'd0);
        chk("stall_lo", lo, 32'd12);
        md_use_d = 1'b0;

        issue(MD_MTHI, 32'd1, 32'd0);
        issue(MD_MTLO, 32'd2, 32'd0);
        md_use_d = 1'b1;
        start = 1'b1; md_op = MD_DIV; a = 32'd9; b = 32'd0;
        #1;
`ifdef MD_DIV0_FAST_EN
        chk("div0_stall", {31'b0, stall}, 32'd0);
`else
        chk("div0_stall", {31'b0, stall}, 32'd1);
`endif
        tick();
        start = 1'b0; md_op = MD_NONE; md_use_d = 1'b0;
        count_busy(n_busy);
`ifdef MD_DIV0_FAST_EN
        chk("div0_busy", n_busy, 32'd0);
`else
        chk("div0_busy", n_busy, 32'd10);
`endif
        chk("div0_hi", hi, 32'd1);
        chk("div0_lo", lo, 32'd2);

        issue(MD_MULT, 32'd7, 32'd9);
        chk("abort_busy1", {31'b0, busy}, 32'd1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        tick(); tick(); tick(); tick();
        chk("abort_lo_hold", lo, 32'd0);
        issue(MD_MTLO, 32'd5, 32'd0);
        chk("mtlo_lo", lo, 32'd5);
        chk("mtlo_hi", hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
